// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo types: tags, register ids, CDB and issue payloads, and
// the multiply reservation-station dispatch/entry records.
package tomasulo_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned TAG_W    = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned ROBID_W  = 5;
    localparam int unsigned RS_MPY_N = 4;

    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [REG_W-1:0]   reg_t;
    typedef logic [ROBID_W-1:0] robid_t;

    typedef struct packed {
        logic   vld;
        tag_t   tag;
        word_t  wdata;
        reg_t   wa;
        robid_t robid;
    } cdb_t;

    typedef struct packed {
        word_t [1:0] rdata;
        reg_t        wa;
        tag_t        tag;
        robid_t      robid;
    } issue_t;

    typedef struct packed {
        logic  rdy;
        tag_t  tag;
        word_t data;
    } rs_src_t;

    typedef struct packed {
        rs_src_t [1:0] src;
        reg_t          wa;
        tag_t          tag;
        robid_t        robid;
    } rs_dis_t;

    typedef struct packed {
        logic          vld;
        rs_src_t [1:0] src;
        reg_t          wa;
        tag_t          tag;
        robid_t        robid;
    } rs_ent_t;

endpackage

// File: rtl/tomasulo_age_matrix.sv
// NxN older-than matrix: older[i][j] set means entry i was allocated before j.
// Grants the single requester that no other requester is older than.
module tomasulo_age_matrix #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] alloc,
    input  logic [N-1:0] dealloc,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic [N-1:0] older_q [N];
    logic [N-1:0] older_d [N];
    logic         blocked;

    // New entry becomes younger than everyone; freed or new rows drop all claims.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            older_d[i] = older_q[i];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (alloc[j] && (i != j)) begin
                    older_d[i][j] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (alloc[i] || dealloc[i]) begin
                older_d[i] = '0;
            end
        end
    end

    always_comb begin
        grant   = '0;
        blocked = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if ((i != j) && req[j] && older_q[j][i]) begin
                    blocked = 1'b1;
                end
            end
            grant[i] = req[i] & ~blocked;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: rtl/tomasulo_rs_mpy.sv
// Multiply reservation station: holds dispatched ops, snoops the CDB for
// missing operands and issues the oldest ready op to the multiplier.
module tomasulo_rs_mpy
    import tomasulo_pkg::*;
#(
    parameter int unsigned N = RS_MPY_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dis_vld,
    input  rs_dis_t                dis,
    output logic                   dis_rdy,
    input  cdb_t                   cdb,
    input  logic                   exe_busy,
    output logic                   iss_vld,
    output issue_t                 iss,
    output logic [$clog2(N+1)-1:0] occ
);

    localparam int unsigned OCC_W = $clog2(N + 1);

    rs_ent_t          ent_q [N];
    rs_ent_t          ent_d [N];
    logic [N-1:0]     elig;
    logic [N-1:0]     free_oh;
    logic [N-1:0]     alloc_oh;
    logic [N-1:0]     grant;
    logic [N-1:0]     issue_oh;
    logic [OCC_W-1:0] occ_d;
    logic             found;
    logic             accept;
    logic             iss_last_q;
    logic             unused_cdb;

    assign unused_cdb = ^{cdb.wa, cdb.robid};

    // Lowest-index free slot and eligibility, from registered state only.
    always_comb begin
        free_oh = '0;
        elig    = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            elig[i] = ent_q[i].vld & ent_q[i].src[0].rdy & ent_q[i].src[1].rdy;
            if (!ent_q[i].vld && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign accept   = dis_vld & dis_rdy;
    assign alloc_oh = free_oh & {N{accept}};

    tomasulo_age_matrix #(
        .N(N)
    ) u_age (
        .clk    (clk),
        .rst    (rst),
        .alloc  (alloc_oh),
        .dealloc(issue_oh),
        .req    (elig),
        .grant  (grant)
    );

    // exe_busy is the only combinational input into the issue path.
    assign iss_vld  = (|elig) & ~exe_busy & ~iss_last_q;
    assign issue_oh = grant & {N{iss_vld}};

    always_comb begin
        iss = '0;
        for (int i = 0; i < N; i++) begin
            if (issue_oh[i]) begin
                iss.rdata[0] = ent_q[i].src[0].data;
                iss.rdata[1] = ent_q[i].src[1].data;
                iss.wa       = ent_q[i].wa;
                iss.tag      = ent_q[i].tag;
                iss.robid    = ent_q[i].robid;
            end
        end
    end

    // Entry update: allocate (with CDB bypass), retire on issue, or snoop.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            ent_d[i] = ent_q[i];
            if (alloc_oh[i]) begin
                ent_d[i].vld   = 1'b1;
                ent_d[i].wa    = dis.wa;
                ent_d[i].tag   = dis.tag;
                ent_d[i].robid = dis.robid;
                for (int s = 0; s < 2; s++) begin
                    ent_d[i].src[s] = dis.src[s];
                    if (cdb.vld && !dis.src[s].rdy && (dis.src[s].tag == cdb.tag)) begin
                        ent_d[i].src[s].rdy  = 1'b1;
                        ent_d[i].src[s].data = cdb.wdata;
                    end
                end
            end else if (issue_oh[i]) begin
                ent_d[i].vld = 1'b0;
            end else if (ent_q[i].vld && cdb.vld) begin
                for (int s = 0; s < 2; s++) begin
                    if (!ent_q[i].src[s].rdy && (ent_q[i].src[s].tag == cdb.tag)) begin
                        ent_d[i].src[s].rdy  = 1'b1;
                        ent_d[i].src[s].data = cdb.wdata;
                    end
                end
            end
        end
    end

    assign occ_d = occ + OCC_W'(accept) - OCC_W'(|issue_oh);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= '0;
            end
            occ        <= '0;
            dis_rdy    <= 1'b1;
            iss_last_q <= 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                ent_q[i] <= ent_d[i];
            end
            occ        <= occ_d;
            dis_rdy    <= (occ_d != OCC_W'(N));
            iss_last_q <= iss_vld;
        end
    end

endmodule
